// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline skid stages
package pipe_pkg;

   // Fill level of a skid stage: nothing held, head only, head plus skid
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   // Per-boundary payload bundles; each stage instance packs one of these into DATA_W
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] store_val;
      logic [4:0]  rd;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] wb_val;
      logic [4:0]  rd;
      logic        reg_we;
   } mem_wb_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   // Count enabled cycles, hold at all-ones, clear has priority
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (enable && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - 2-entry skid pipeline register; PIPE_STAGE_STALL_CNT_EN adds stall_cycles
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                 DATA_W = 32,
   parameter logic [DATA_W-1:0]  BUBBLE = '0,
   parameter int                 CNT_W  = 16
) (
   input  logic              clk,
`ifdef PIPE_STAGE_STALL_CNT_EN
   output logic [CNT_W-1:0]  stall_cycles,
`endif
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   pipe_state_t       state;
   pipe_state_t       state_next;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic              in_fire;
   logic              out_fire;

   // Handshakes are suppressed during flush so no beat moves in that cycle
   always_comb begin
      in_fire  = in_valid & in_ready & ~flush;
      out_fire = out_valid & out_ready & ~flush;
   end

   // State register: reset and flush both return to EMPTY
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Next fill level from the two handshakes
   always_comb begin
      state_next = state;
      case (state)
         EMPTY: if (in_fire) state_next = ONE;
         ONE: begin
            if (in_fire && !out_fire) begin
               state_next = FULL;
            end else if (!in_fire && out_fire) begin
               state_next = EMPTY;
            end
         end
         FULL: if (out_fire) state_next = ONE;
         default: state_next = EMPTY;
      endcase
   end

   // Payload registers; empty slots always hold BUBBLE so out_data needs no mux
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         main_q <= BUBBLE;
         skid_q <= BUBBLE;
      end else begin
         case (state)
            EMPTY: if (in_fire) main_q <= in_data;
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= in_data;
               end else if (in_fire) begin
                  skid_q <= in_data;
               end else if (out_fire) begin
                  main_q <= BUBBLE;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_q <= skid_q;
                  skid_q <= BUBBLE;
               end
            end
            default: begin
               main_q <= BUBBLE;
               skid_q <= BUBBLE;
            end
         endcase
      end
   end

   // Outputs decoded from flops only, keeping in_ready free of downstream paths
   always_comb begin
      in_ready  = (state != FULL);
      out_valid = (state != EMPTY);
      out_data  = main_q;
      case (state)
         EMPTY:   occupancy = OCC_EMPTY;
         ONE:     occupancy = OCC_ONE;
         default: occupancy = OCC_FULL;
      endcase
   end

`ifdef PIPE_STAGE_STALL_CNT_EN
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk    (clk),
      .clear  (reset),
      .enable (out_valid & ~out_ready),
      .count  (stall_cycles)
   );
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid (PIPE_STAGE_STALL_CNT_EN optional)
module tb_pipe_stage_skid;

   localparam logic [31:0] BUB = 32'h0000_0013;
   localparam int          CW  = 4;
   localparam int          CNT_MAX = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [CW-1:0] stall_cycles;
`endif

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] q[$];
   int          m_cnt = 0;

   pipe_stage_skid #(
      .DATA_W (32),
      .BUBBLE (BUB),
      .CNT_W  (CW)
   ) dut (
      .clk          (clk),
`ifdef PIPE_STAGE_STALL_CNT_EN
      .stall_cycles (stall_cycles),
`endif
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .occupancy    (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic compare_all();
      check("model_in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("model_out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("model_out_data", out_data, (q.size() > 0) ? q[0] : BUB);
      check("model_occupancy", 32'(occupancy), 32'(q.size()));
`ifdef PIPE_STAGE_STALL_CNT_EN
      check("model_stall_cycles", 32'(stall_cycles), 32'(m_cnt));
`endif
   endtask

   // One clock: drive at negedge, advance the queue model at posedge, check at next negedge
   task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] d, input logic ordy);
      logic m_in_fire;
      logic m_out_fire;
      reset     = r;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      m_in_fire  = iv && (q.size() < 2) && !f;
      m_out_fire = (q.size() > 0) && ordy && !f;
      if (r) begin
         m_cnt = 0;
      end else if ((q.size() > 0) && !ordy && (m_cnt < CNT_MAX)) begin
         m_cnt = m_cnt + 1;
      end
      @(posedge clk);
      if (r || f) begin
         q.delete();
      end else begin
         if (m_out_fire) void'(q.pop_front());
         if (m_in_fire) q.push_back(d);
      end
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      // Reset with a beat presented: beat must not be captured
      step(1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, BUB);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("rst_not_captured", 32'(out_valid), 32'd0);

      // Streaming at full rate with out_ready held high
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b1, 32'(16 + i), 1'b1);
         check("stream_data", out_data, 32'(16 + i));
         check("stream_in_ready", 32'(in_ready), 32'd1);
         check("stream_occ", 32'(occupancy), 32'd1);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("stream_drained", 32'(out_valid), 32'd0);

      // Fill both entries under back-pressure, then drain in order
      step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h21, 1'b0);
      check("full_occ", 32'(occupancy), 32'd2);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_head", out_data, 32'h20);
      step(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
      check("full_head_stable", out_data, 32'h20);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("drain_head1", out_data, 32'h21);
      check("drain_occ1", 32'(occupancy), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("drain_occ0", 32'(occupancy), 32'd0);
      check("drain_bubble", out_data, BUB);

      // Flush from FULL drops held beats and the beat offered in the flush cycle
      step(1'b0, 1'b0, 1'b1, 32'h30, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h31, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h32, 1'b0);
      check("flush_occ", 32'(occupancy), 32'd0);
      check("flush_data", out_data, BUB);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("flush_no_32", 32'(out_valid), 32'd0);

      // Simultaneous in/out fire in ONE keeps occupancy at 1
      step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
      check("one_head40", out_data, 32'h40);
      step(1'b0, 1'b0, 1'b1, 32'h41, 1'b1);
      check("one_head41", out_data, 32'h41);
      check("one_occ", 32'(occupancy), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

`ifdef PIPE_STAGE_STALL_CNT_EN
      // Stall counter saturates, survives flush, clears on reset
      step(1'b0, 1'b0, 1'b1, 32'h50, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("stall_sat", 32'(stall_cycles), 32'd15);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("stall_after_flush", 32'(stall_cycles), 32'd15);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("stall_after_reset", 32'(stall_cycles), 32'd0);
`endif

      // Randomized traffic against the queue model
      for (int i = 0; i < 600; i++) begin
         logic r;
         logic f;
         logic iv;
         logic ordy;
         r    = ($urandom_range(0, 59) == 0);
         f    = ($urandom_range(0, 24) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         step(r, f, iv, $urandom, ordy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
